// File: rtl/line_mem_responder.sv
// Memory-side line responder: serves one line read/write at a time against a
// word-wide backing store, one word per cycle after a fixed access latency.
module line_mem_responder #(
  parameter int unsigned CACHE_BITS  = 8,
  parameter int unsigned DEPTH_LINES = 16,
  parameter int unsigned ACCESS_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic [25:2]                  mem_addr,
  input  logic [CACHE_BITS-1:2][31:0]  line_store,
  output logic [CACHE_BITS-1:2][31:0]  line_read,
  output logic                         mem_ready,
  output logic                         mem_done
);

  localparam int unsigned LINE_WORDS  = CACHE_BITS - 2;
  localparam int unsigned JW          = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned SW          = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned AW          = SW + JW;
  localparam int unsigned STORE_WORDS = 1 << AW;
  localparam int unsigned CW          = 4;
  localparam logic [JW-1:0] LAST_J    = JW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAT_INIT  = CW'((ACCESS_LAT > 0) ? ACCESS_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, DONE} state_t;

  state_t                      state;
  logic [SW-1:0]               slot;
  logic                        is_wr;
  logic [CW-1:0]               cnt;
  logic [JW-1:0]               j;
  logic [LINE_WORDS-1:0][31:0] wbuf;
  logic [LINE_WORDS-1:0][31:0] rbuf;
  logic [31:0]                 store [STORE_WORDS];
  logic [AW-1:0]               word_addr;
  logic [31:0]                 rd_word;

  assign word_addr = {slot, j};
  assign rd_word   = store[word_addr];

  assign mem_ready = (state == IDLE);
  assign mem_done  = (state == DONE);
  assign line_read = rbuf;

  // Request sequencing; write wins when both enables are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= '0;
      rbuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_w_en || mem_r_en) begin
            is_wr <= mem_w_en;
            slot  <= mem_addr[CACHE_BITS+SW-1:CACHE_BITS];
            j     <= '0;
            if (mem_w_en) wbuf <= line_store;
            if (ACCESS_LAT > 0) begin
              state <= LAT;
              cnt   <= LAT_INIT;
            end else begin
              state <= mem_w_en ? WR_BURST : RD_BURST;
            end
          end
        end
        LAT: begin
          if (cnt == '0) state <= is_wr ? WR_BURST : RD_BURST;
          else           cnt   <= cnt - 1'b1;
        end
        RD_BURST: begin
          rbuf[j] <= rd_word;
          if (j == LAST_J) state <= DONE;
          else             j     <= j + 1'b1;
        end
        WR_BURST: begin
          if (j == LAST_J) state <= DONE;
          else             j     <= j + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is never reset; a word written on a reset edge still commits.
  always_ff @(posedge clk) begin
    if (state == WR_BURST) store[word_addr] <= wbuf[j];
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder (latency 2 and latency 0 instances).
module tb_line_mem_responder;

  typedef logic [7:2][31:0] line_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic        r_en_z = 1'b0, w_en_z = 1'b0;
  logic [25:2] mem_addr = '0;
  line_t       line_store = '0;
  line_t       line_read, line_read_z;
  logic        mem_ready, mem_done, ready_z, done_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_mem_responder #(.CACHE_BITS(8), .DEPTH_LINES(16), .ACCESS_LAT(2)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .line_store(line_store), .line_read(line_read),
    .mem_ready(mem_ready), .mem_done(mem_done)
  );

  line_mem_responder #(.CACHE_BITS(8), .DEPTH_LINES(16), .ACCESS_LAT(0)) dut_z (
    .clk(clk), .rst(rst), .mem_r_en(r_en_z), .mem_w_en(w_en_z),
    .mem_addr(mem_addr), .line_store(line_store), .line_read(line_read_z),
    .mem_ready(ready_z), .mem_done(done_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic line_t mk(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < 6; k++) l[k+2] = base + 32'(k);
    return l;
  endfunction

  function automatic logic [25:2] la(input int unsigned ln);
    return {18'(ln), 6'd0};
  endfunction

  // One request from cycle 0; records the cycle of the completion pulse.
  task automatic request(input bit sel, input bit w, input bit r, input int unsigned ln,
                         input line_t data, input int exp_cyc, input string tag);
    int at;
    int pulses;
    at = 0;
    pulses = 0;
    mem_addr   = la(ln);
    line_store = data;
    if (sel) begin w_en_z = w; r_en_z = r; end
    else     begin mem_w_en = w; mem_r_en = r; end
    step();
    check({tag, "_busy"}, 192'(sel ? ready_z : mem_ready), 192'(0));
    w_en_z = 0; r_en_z = 0; mem_w_en = 0; mem_r_en = 0;
    mem_addr = '0;
    line_store = '0;
    for (int c = 1; c <= 20; c++) begin
      if (sel ? done_z : mem_done) begin
        pulses++;
        if (at == 0) at = c;
      end
      step();
    end
    check({tag, "_done_cycle"}, 192'(at), 192'(exp_cyc));
    check({tag, "_pulses"}, 192'(pulses), 192'(1));
    check({tag, "_ready"}, 192'(sel ? ready_z : mem_ready), 192'(1));
  endtask

  initial begin
    line_t exp;
    int p, a1, a2;

    step();
    step();
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      check("rst_ready", 192'(mem_ready), 192'(1));
      check("rst_done", 192'(mem_done), 192'(0));
      check("rst_line", line_read, 192'(0));
      step();
    end
    check("rst_ready_z", 192'(ready_z), 192'(1));

    request(0, 1, 0, 3, mk(32'hA0), 9, "wr_a");
    request(0, 0, 1, 3, '0, 9, "rd_a");
    check("rd_a_data", line_read, mk(32'hA0));

    request(0, 0, 1, 19, '0, 9, "rd_alias");
    check("rd_alias_data", line_read, mk(32'hA0));

    request(0, 1, 1, 7, {6{32'h55}}, 9, "both");
    request(0, 0, 1, 7, '0, 9, "rd_both");
    check("rd_both_data", line_read, {6{32'h55}});

    // Read enable held through the IDLE cycle after the pulse.
    mem_addr = la(3);
    mem_r_en = 1;
    step();
    p = 0; a1 = 0; a2 = 0;
    for (int c = 1; c <= 30; c++) begin
      if (mem_done) begin
        p++;
        if (p == 1) a1 = c;
        else if (p == 2) a2 = c;
      end
      if (c == 11) mem_r_en = 0;
      step();
    end
    check("hold_pulses", 192'(p), 192'(2));
    check("hold_first", 192'(a1), 192'(9));
    check("hold_second", 192'(a2), 192'(19));

    // Reset in the middle of a write burst.
    request(0, 1, 0, 5, mk(32'hC0), 9, "wr_c");
    request(0, 0, 1, 5, '0, 9, "rd_c");
    check("rd_c_data", line_read, mk(32'hC0));
    mem_addr = la(5);
    line_store = mk(32'hB0);
    mem_w_en = 1;
    step();
    mem_w_en = 0;
    step();
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check("abort_ready", 192'(mem_ready), 192'(1));
    check("abort_done", 192'(mem_done), 192'(0));
    check("abort_line", line_read, 192'(0));
    p = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_done) p++;
      step();
    end
    check("abort_no_pulse", 192'(p), 192'(0));
    exp = mk(32'hC0);
    exp[2] = 32'hB0;
    exp[3] = 32'hB1;
    request(0, 0, 1, 5, '0, 9, "rd_abort");
    check("rd_abort_data", line_read, exp);

    request(1, 1, 0, 3, mk(32'hD0), 7, "z_wr");
    request(1, 0, 1, 3, '0, 7, "z_rd");
    check("z_rd_data", line_read_z, mk(32'hD0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the cache's line-fill/line-store interface. Accepts one line request at a time on `mem_r_en`/`mem_w_en`/`mem_addr`, and services it against an internal word-wide backing store one word per cycle after a programmable access latency. For a read it returns the assembled line on `line_read`; for a write it commits the captured `line_store`. Completion is signalled with a single-cycle `mem_done` pulse. It sits directly below the cache and stands in for external DRAM in simulation and FPGA bring-up.

## Interface
- `CACHE_BITS`, 8: line element indices run `CACHE_BITS-1` down to 2, so a line is `LINE_WORDS = CACHE_BITS-2` words (6 at default).
- `DEPTH_LINES`, 16: number of line slots in the backing store; must be a power of two.
- `ACCESS_LAT`, 2: idle wait cycles between request acceptance and the first word transfer; valid range 0..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `mem_r_en`  input  1  line read request.
- `mem_w_en`  input  1  line write request.
- `mem_addr`  input  [25:2]  word address; the line number is `mem_addr[25:CACHE_BITS]`.
- `line_store`  input  [CACHE_BITS-1:2][31:0]  line to write; sampled only at acceptance.
- `line_read`  output  [CACHE_BITS-1:2][31:0]  last line read; registered.
- `mem_ready`  output  1  high iff the state is IDLE.
- `mem_done`  output  1  one-cycle completion pulse; registered state decode.

## Operation
- States:
  - IDLE: accepts requests.
  - LAT: waits for the access latency.
  - RD_BURST, WR_BURST: move one word per cycle.
  - DONE: signals completion.
- Backing store mapping:
  - Slot = `mem_addr[CACHE_BITS+log2(DEPTH_LINES)-1:CACHE_BITS]`; higher line-number bits are ignored, so addresses alias modulo DEPTH_LINES.
  - Burst word j (0..LINE_WORDS-1) maps to line element j+2 and to storage word `{slot, j}`.
- Acceptance (IDLE only), evaluated at the clock edge:
  - `mem_w_en=1`: latch slot and direction=write, capture `line_store` into the internal buffer.
  - `mem_w_en=0`, `mem_r_en=1`: latch slot and direction=read.
  - Both high: the write wins and the read is ignored; a read then requires a new request.
  - Accepted request with `ACCESS_LAT>0`: go to LAT with the counter at ACCESS_LAT-1. With `ACCESS_LAT=0`: go straight to the burst state for the latched direction.
  - Neither enable high: stay in IDLE.
- LAT: decrement the counter; when it reaches 0, go to the burst state at j=0.
- Requests and enables are ignored outside IDLE. `mem_addr` and `line_store` may change after acceptance without effect.
- RD_BURST: each cycle, read storage word `{slot,j}` combinationally and register it into `line_read[j+2]`. After j=LINE_WORDS-1, go to DONE.
- WR_BURST: each cycle, write buffer word j to storage `{slot,j}`. After j=LINE_WORDS-1, go to DONE.
- DONE: `mem_done=1` for exactly this cycle, then go to IDLE.
  - A request still asserted in the following IDLE cycle is accepted as a new request; the requester must drop its enable on the cycle it observes `mem_done`.
- `line_read` changes only during RD_BURST. It is stable from DONE until the next read burst. Elements not yet overwritten during a burst keep their old values.
- Reset (any state): next state IDLE, `mem_done=0`, `line_read` cleared to 0, counters cleared.
  - Storage contents are not reset.
  - Words already committed by an interrupted write remain; there is no completion pulse for the aborted request.

## Timing
- Out of reset: `mem_ready=1`, `mem_done=0`, `line_read=0`.
- Request first seen high in IDLE in cycle 0 → `mem_done` high in cycle `ACCESS_LAT+LINE_WORDS+1` (9 at defaults); `mem_ready` is low in cycles 1 through the DONE cycle and high again the cycle after.
- Throughput: one line per `ACCESS_LAT+LINE_WORDS+2` cycles for back-to-back requests.
- Read data hazard: a read accepted immediately after a write to the same slot returns the new data, because the write finishes before DONE.

## Test plan
- Reset, then hold idle for 5 cycles → `mem_ready=1`, `mem_done=0`, `line_read=0` throughout.
- Write slot 3 (`mem_addr[25:8]=3`) with words 0xA0..0xA5 at elements 2..7, then read slot 3 with `ACCESS_LAT=2` → `mem_done` pulses exactly in cycle 9 after each acceptance; `line_read[2..7]=0xA0..0xA5`.
- Read at line number 19 after writing line 3 with `DEPTH_LINES=16` → returns 0xA0..0xA5 (aliasing).
- Both enables high in IDLE with `line_store` all 0x55 → write executes and one `mem_done` pulse occurs; a following read returns all 0x55.
- Requester holds `mem_r_en` one cycle past `mem_done` → a second read is accepted; exactly two pulses, 10 cycles apart.
- Assert `rst` during cycle 4 of a write of 0xBx data over old 0xCx data → IDLE next cycle, no `mem_done`, `line_read=0`. A later read returns the words committed before reset (words 0..1) with the remaining words still holding old data.
- Rerun the write/read scenario with `ACCESS_LAT=0` → `mem_done` in cycle 7.
